// File: rtl/opamp_bank_ctrl.sv
// Power-up/config controller for a bank of opamps sharing one bias generator.
// Serial frames arrive on synchronised pins; the bias settles, then the channels enable one after another.
module opamp_bank_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int TRIM_W      = 4,
  parameter int SETTLE_CYC  = 256,
  parameter int STAGGER_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_sclk,
  input  logic              cfg_sdata,
  input  logic              cfg_latch,
  output logic              bias_en,
  output logic [TRIM_W-1:0] bias_trim,
  output logic [NUM_CH-1:0] ch_en,
  output logic              busy,
  output logic              ready,
  output logic              cfg_err
);

  localparam int FRAME_W = NUM_CH + TRIM_W;
  localparam int MAX_CYC = (SETTLE_CYC > STAGGER_CYC) ? SETTLE_CYC : STAGGER_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int BC_W    = $clog2(FRAME_W + 2);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_OFF, S_SETTLE, S_RAMP, S_ON} state_t;

  // [0],[1] synchroniser stages, [2] previous value for edge detect
  logic [2:0]         r_sclk_sh;
  logic [2:0]         r_latch_sh;
  logic [1:0]         r_sdata_sh;
  logic               w_sclk_p;
  logic               w_latch_p;

  logic [FRAME_W-1:0] r_shadow;
  logic [BC_W-1:0]    r_bitcnt;
  logic [FRAME_W-1:0] r_act_cfg;
  logic               r_load;
  logic               r_cfg_err;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_CH-1:0]  r_ch_en;
  logic [NUM_CH-1:0]  r_fsm_req;
  logic [TRIM_W-1:0]  r_bias_trim;

  state_t             w_state_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [IDX_W-1:0]   w_idx_nx;
  logic [NUM_CH-1:0]  w_chen_nx;
  logic [NUM_CH-1:0]  w_req_nx;
  logic               w_enter;
  logic [IDX_W-1:0]   w_enter_idx;
  logic [NUM_CH-1:0]  w_act_req;

  assign w_sclk_p  = r_sclk_sh[1] & ~r_sclk_sh[2];
  assign w_latch_p = r_latch_sh[1] & ~r_latch_sh[2];
  assign w_act_req = r_act_cfg[FRAME_W-1:TRIM_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sh  <= '0;
      r_latch_sh <= '0;
      r_sdata_sh <= '0;
      r_shadow   <= '0;
      r_bitcnt   <= '0;
      r_act_cfg  <= '0;
      r_load     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_sclk_sh  <= {r_sclk_sh[1:0], cfg_sclk};
      r_latch_sh <= {r_latch_sh[1:0], cfg_latch};
      r_sdata_sh <= {r_sdata_sh[0], cfg_sdata};
      r_load     <= 1'b0;
      // A latch wins over a coincident shift so the committed frame is the one counted
      if (w_latch_p) begin
        r_bitcnt <= '0;
        if (r_bitcnt == BC_W'(FRAME_W)) begin
          r_act_cfg <= r_shadow;
          r_cfg_err <= 1'b0;
          r_load    <= 1'b1;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (w_sclk_p) begin
        r_shadow <= {r_shadow[FRAME_W-2:0], r_sdata_sh[1]};
        if (r_bitcnt != BC_W'(FRAME_W + 1)) begin
          r_bitcnt <= r_bitcnt + BC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_ch_en     <= '0;
      r_fsm_req   <= '0;
      r_bias_trim <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_ch_en     <= w_chen_nx;
      r_fsm_req   <= w_req_nx;
      r_bias_trim <= r_act_cfg[TRIM_W-1:0];
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_idx_nx    = r_idx;
    w_chen_nx   = r_ch_en;
    w_req_nx    = r_fsm_req;
    w_enter     = 1'b0;
    w_enter_idx = r_idx;

    case (r_state)
      S_SETTLE: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nx  = S_RAMP;
          w_enter     = 1'b1;
          w_enter_idx = '0;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      S_RAMP: begin
        if (r_cnt <= CNT_W'(1)) begin
          if (r_idx == IDX_W'(NUM_CH - 1)) begin
            w_state_nx = S_ON;
          end else begin
            w_enter     = 1'b1;
            w_enter_idx = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (r_load) begin
      w_req_nx  = w_act_req;
      w_chen_nx = r_ch_en & w_act_req;
      if (w_act_req == '0) begin
        w_state_nx = S_OFF;
        w_chen_nx  = '0;
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
        w_enter    = 1'b0;
      end else if (r_state == S_OFF) begin
        w_state_nx = S_SETTLE;
        w_cnt_nx   = CNT_W'(SETTLE_CYC);
        w_enter    = 1'b0;
      end else if ((r_state == S_RAMP || r_state == S_ON) &&
                   ((w_act_req & ~r_fsm_req) != '0)) begin
        w_state_nx  = S_RAMP;
        w_enter     = 1'b1;
        w_enter_idx = '0;
      end
    end

    // Entering a slot: a fresh channel waits the stagger, anything else costs one cycle
    if (w_enter) begin
      w_idx_nx = w_enter_idx;
      if (w_act_req[w_enter_idx] && !w_chen_nx[w_enter_idx]) begin
        w_chen_nx[w_enter_idx] = 1'b1;
        w_cnt_nx               = CNT_W'(STAGGER_CYC);
      end else begin
        w_cnt_nx = CNT_W'(1);
      end
    end
  end

  assign bias_en   = (r_state != S_OFF);
  assign busy      = (r_state == S_SETTLE) || (r_state == S_RAMP);
  assign ready     = (r_state == S_ON);
  assign ch_en     = r_ch_en;
  assign bias_trim = r_bias_trim;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_opamp_bank_ctrl.sv
// Self-checking bench for opamp_bank_ctrl: directed scenarios plus randomised frames
// compared against a timeline model of the power-up sequence.
module tb_opamp_bank_ctrl;
  localparam int NUM_CH  = 2;
  localparam int TRIM_W  = 4;
  localparam int SETTLE  = 8;
  localparam int STAGGER = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_sclk = 1'b0;
  logic cfg_sdata = 1'b0;
  logic cfg_latch = 1'b0;
  logic              bias_en;
  logic [TRIM_W-1:0] bias_trim;
  logic [NUM_CH-1:0] ch_en;
  logic              busy;
  logic              ready;
  logic              cfg_err;

  int n_total = 0;
  int n_pass  = 0;

  // {bias_en, busy, ready, ch_en, bias_trim}
  logic [8:0] obs;
  assign obs = {bias_en, busy, ready, ch_en, bias_trim};

  opamp_bank_ctrl #(
    .NUM_CH(NUM_CH), .TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE), .STAGGER_CYC(STAGGER)
  ) dut (
    .clk(clk), .rst(rst), .cfg_sclk(cfg_sclk), .cfg_sdata(cfg_sdata), .cfg_latch(cfg_latch),
    .bias_en(bias_en), .bias_trim(bias_trim), .ch_en(ch_en), .busy(busy), .ready(ready),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    cfg_sclk = 1'b0; cfg_latch = 1'b0; cfg_sdata = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_sdata = v[i];
      tick(2);
      cfg_sclk = 1'b1;
      tick(3);
      cfg_sclk = 1'b0;
      tick(3);
    end
  endtask

  // Leaves the bench one cycle after the config load edge
  task automatic do_latch();
    cfg_latch = 1'b1;
    tick(4);
    cfg_latch = 1'b0;
  endtask

  // Expected outputs k cycles after the first cycle following a load from OFF
  function automatic logic [8:0] model(input logic [1:0] req, input logic [3:0] trim, input int k);
    int t;
    logic [1:0] ce;
    logic b, rdy;
    ce = 2'b00;
    b = (req != 2'b00);
    t = SETTLE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i]) begin
        if (k >= t) ce[i] = 1'b1;
        t += STAGGER;
      end else begin
        t += 1;
      end
    end
    rdy = b && (k >= t);
    return {b, b & ~rdy, rdy, ce, trim};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_total++;
    if (obs !== 9'd0 || cfg_err !== 1'b0)
      $display("FAIL reset: outputs=%h err=%b expected 000 err=0", obs, cfg_err);
    else n_pass++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_powerup();
    logic [8:0] exp_v;
    do_reset();
    send_bits(8'b0011_1010, 6);
    do_latch();
    for (int k = 0; k < SETTLE + NUM_CH * STAGGER + 3; k++) begin
      exp_v = model(2'b11, 4'hA, k);
      n_total++;
      if (obs !== exp_v)
        $display("FAIL powerup k=%0d: got %b expected %b", k, obs, exp_v);
      else n_pass++;
      tick(1);
    end
  endtask

  task automatic test_bad_frame();
    send_bits(8'b0001_0110, 5);
    do_latch();
    n_total++;
    if (cfg_err !== 1'b1 || obs !== {1'b1, 1'b0, 1'b1, 2'b11, 4'hA})
      $display("FAIL bad_frame: err=%b out=%b expected err=1 out=%b", cfg_err, obs,
               {1'b1, 1'b0, 1'b1, 2'b11, 4'hA});
    else n_pass++;
    send_bits(8'b0001_0111, 6);
    do_latch();
    n_total++;
    if (cfg_err !== 1'b0 || obs !== {1'b1, 1'b0, 1'b1, 2'b01, 4'h7})
      $display("FAIL recover_frame: err=%b out=%b expected err=0 out=%b", cfg_err, obs,
               {1'b1, 1'b0, 1'b1, 2'b01, 4'h7});
    else n_pass++;
  endtask

  task automatic test_add_channel();
    send_bits(8'b0011_0101, 6);
    do_latch();
    n_total++;
    if (obs !== {1'b1, 1'b1, 1'b0, 2'b01, 4'h5})
      $display("FAIL add_ch load+1: got %b expected %b", obs, {1'b1, 1'b1, 1'b0, 2'b01, 4'h5});
    else n_pass++;
    tick(1);
    n_total++;
    if (obs !== {1'b1, 1'b1, 1'b0, 2'b11, 4'h5})
      $display("FAIL add_ch load+2: got %b expected %b", obs, {1'b1, 1'b1, 1'b0, 2'b11, 4'h5});
    else n_pass++;
    tick(STAGGER - 1);
    n_total++;
    if (ready !== 1'b0)
      $display("FAIL add_ch early_ready: got %b expected 0", ready);
    else n_pass++;
    tick(1);
    n_total++;
    if (obs !== {1'b1, 1'b0, 1'b1, 2'b11, 4'h5})
      $display("FAIL add_ch on: got %b expected %b", obs, {1'b1, 1'b0, 1'b1, 2'b11, 4'h5});
    else n_pass++;
  endtask

  task automatic test_disable();
    send_bits(8'b0000_0000, 6);
    do_latch();
    n_total++;
    if (obs !== 9'd0)
      $display("FAIL disable load+1: got %b expected 0", obs);
    else n_pass++;
    tick(SETTLE + 2);
    n_total++;
    if (obs !== 9'd0)
      $display("FAIL disable hold: got %b expected 0", obs);
    else n_pass++;
  endtask

  task automatic test_skip_channel();
    logic [8:0] exp_v;
    do_reset();
    send_bits(8'b0010_0011, 6);
    do_latch();
    for (int k = 0; k < SETTLE + STAGGER + 4; k++) begin
      exp_v = model(2'b10, 4'h3, k);
      n_total++;
      if (obs !== exp_v)
        $display("FAIL skip k=%0d: got %b expected %b", k, obs, exp_v);
      else n_pass++;
      tick(1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bits(8'b0011_1010, 6);
    do_latch();
    tick(3);
    n_total++;
    if (busy !== 1'b1 || ch_en !== 2'b00)
      $display("FAIL mid_settle pre: busy=%b ch_en=%b expected 1 00", busy, ch_en);
    else n_pass++;
    rst = 1'b1;
    tick(1);
    n_total++;
    if (obs !== 9'd0 || cfg_err !== 1'b0)
      $display("FAIL mid_settle reset: got %b err=%b expected 0", obs, cfg_err);
    else n_pass++;
    rst = 1'b0;
    tick(SETTLE + 2 * STAGGER);
    n_total++;
    if (obs !== 9'd0)
      $display("FAIL mid_settle resume: got %b expected 0", obs);
    else n_pass++;
    send_bits(8'b0011_1010, 6);
    do_latch();
    tick(SETTLE + 1);
    n_total++;
    if (ch_en !== 2'b01 || busy !== 1'b1)
      $display("FAIL mid_ramp pre: ch_en=%b busy=%b expected 01 1", ch_en, busy);
    else n_pass++;
    rst = 1'b1;
    tick(1);
    n_total++;
    if (obs !== 9'd0)
      $display("FAIL mid_ramp reset: got %b expected 0", obs);
    else n_pass++;
    rst = 1'b0;
    tick(2 * STAGGER);
    n_total++;
    if (obs !== 9'd0)
      $display("FAIL mid_ramp resume: got %b expected 0", obs);
    else n_pass++;
  endtask

  task automatic test_coincident();
    do_reset();
    send_bits(8'b0001_1100, 6);
    cfg_sdata = 1'b1;
    cfg_sclk  = 1'b1;
    cfg_latch = 1'b1;
    tick(4);
    cfg_sclk  = 1'b0;
    cfg_latch = 1'b0;
    n_total++;
    if (cfg_err !== 1'b0 || obs !== {1'b1, 1'b1, 1'b0, 2'b00, 4'hC})
      $display("FAIL coincident: err=%b out=%b expected err=0 out=%b", cfg_err, obs,
               {1'b1, 1'b1, 1'b0, 2'b00, 4'hC});
    else n_pass++;
    tick(3);
    send_bits(8'b0000_0110, 6);
    do_latch();
    n_total++;
    if (cfg_err !== 1'b0 || obs !== {5'b0, 4'h6})
      $display("FAIL coincident_next: err=%b out=%b expected err=0 out=%b", cfg_err, obs,
               {5'b0, 4'h6});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [3:0] trim;
    logic [7:0] junk;
    logic [8:0] exp_v;
    int n;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      req  = 2'($urandom_range(0, 3));
      trim = 4'($urandom_range(0, 15));
      send_bits({2'b00, req, trim}, 6);
      do_latch();
      for (int k = 0; k < SETTLE + NUM_CH * STAGGER + 2; k++) begin
        exp_v = model(req, trim, k);
        n_total++;
        if (obs !== exp_v)
          $display("FAIL random it=%0d req=%b trim=%h k=%0d: got %b expected %b",
                   it, req, trim, k, obs, exp_v);
        else n_pass++;
        tick(1);
      end
      do_reset();
      n = $urandom_range(0, 4);
      n = (n < 3) ? n + 3 : n + 4;
      junk = 8'($urandom_range(0, 255));
      send_bits(junk, n);
      do_latch();
      n_total++;
      if (cfg_err !== 1'b1 || obs !== 9'd0)
        $display("FAIL random_badlen n=%0d: err=%b out=%b expected err=1 out=0", n, cfg_err, obs);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_bad_frame();
    test_add_channel();
    test_disable();
    test_skip_channel();
    test_reset_mid();
    test_coincident();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
